count_display: RTL



---
 rtl/count_display_if.sv | 11 +
 rtl/count_display.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/count_display_if.sv
// Display-side bus of count_display: the count/blank inputs from the counter
// and the active-low segment/anode pins driven towards the board.
interface count_display_if;
    logic [7:0] count;
    logic       blank;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (output count, output blank, input seg, input an);
    modport slave  (input count, input blank, output seg, output an);
endinterface

// File: rtl/count_display.sv
// Shows an 8-bit count in decimal on a 3-digit multiplexed seven-segment display
// using a free-running 10-cycle shift-and-add-3 converter and a digit scanner.
module count_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input logic            Clk100M,
    input logic            Rst_n,
    count_display_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t        state_q;
    logic [2:0]    step_q;
    logic [7:0]    bin_q;
    logic [11:0]   bcd_q;
    logic [3:0]    hundreds_q, tens_q, ones_q;
    logic [CW-1:0] refresh_q;
    logic [1:0]    digit_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;

    logic [7:0]    bin_d;
    logic [11:0]   bcd_d;
    logic [3:0]    selNibble;
    logic          selBlank;
    logic [3:0]    anSel;
    logic [6:0]    seg_d;

    function automatic logic [11:0] addThree(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int n = 0; n < 3; n++) begin
            if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        {bcd_d, bin_d} = {addThree(bcd_q), bin_q} << 1;
    end

    // Display regs are written only in UPDATE, so the scanner never sees a torn value
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            step_q     <= 3'd0;
            bin_q      <= 8'd0;
            bcd_q      <= 12'd0;
            hundreds_q <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    bin_q   <= bus.count;
                    bcd_q   <= 12'd0;
                    step_q  <= 3'd0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    bin_q  <= bin_d;
                    bcd_q  <= bcd_d;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) state_q <= UPDATE;
                end
                UPDATE: begin
                    hundreds_q <= bcd_q[11:8];
                    tens_q     <= bcd_q[7:4];
                    ones_q     <= bcd_q[3:0];
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            refresh_q <= '0;
            digit_q   <= 2'd0;
        end else if (refresh_q == REFRESH_LAST) begin
            refresh_q <= '0;
            digit_q   <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    always_comb begin
        selNibble = ones_q;
        selBlank  = 1'b0;
        anSel     = 4'b1110;
        case (digit_q)
            2'd1: begin
                selNibble = tens_q;
                selBlank  = LZ_SUPPRESS && (hundreds_q == 4'd0) && (tens_q == 4'd0);
                anSel     = 4'b1101;
            end
            2'd2: begin
                selNibble = hundreds_q;
                selBlank  = LZ_SUPPRESS && (hundreds_q == 4'd0);
                anSel     = 4'b1011;
            end
            default: ;
        endcase
        seg_d = selBlank ? 7'h7F : encode(selNibble);
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
        end else if (bus.blank) begin
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
        end else begin
            seg_q <= seg_d;
            an_q  <= anSel;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule
